rv_stream_source: RTL and testbench

Ready/valid stream initiator that drives the write (push) side of the team's FIFO and any other ready/valid sink. On `start` it emits `num_items` data beats built from a selectable pattern. An LFSR-controlled throttle inserts idle cycles. The block obeys the valid-stability rules that the FIFO formal properties assume, so it serves both as a simulation traffic source and as a constrained environment model.

---
 rtl/rv_stream_source.sv | 150 +++++++++++++++
 tb/tb_rv_stream_source.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/rv_stream_source.sv
`default_nettype none
// ============================================================================
// rv_stream_source : ready/valid burst initiator with pattern data and LFSR throttle
// Revision: 1.0
// ============================================================================
module rv_stream_source #(
  parameter int          DATA_WIDTH  = 8,
  parameter int          COUNT_WIDTH = 16,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [COUNT_WIDTH-1:0] num_items,
  input  logic [1:0]             mode,
  input  logic [DATA_WIDTH-1:0]  base,
  input  logic [3:0]             throttle,
  input  logic                   abort,
  output logic                   m_valid,
  output logic [DATA_WIDTH-1:0]  m_data,
  input  logic                   m_ready,
  output logic                   busy,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] sent_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [15:0] LFSR_INIT = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [15:0] LFSR_POLY = 16'hB400;

  state_t                 state, state_nxt;
  logic [15:0]            lfsr, lfsr_nxt;
  logic                   valid_nxt;
  logic [DATA_WIDTH-1:0]  data_nxt;
  logic [COUNT_WIDTH-1:0] idx, idx_nxt;
  logic [COUNT_WIDTH-1:0] count_nxt;
  logic [COUNT_WIDTH-1:0] num_q, num_nxt;
  logic [1:0]             mode_q, mode_nxt;
  logic [DATA_WIDTH-1:0]  base_q, base_nxt;
  logic [3:0]             throttle_q, throttle_nxt;

  logic                   hs;
  logic                   last_beat;
  logic [15:0]            lfsr_step;
  logic [DATA_WIDTH-1:0]  idx_lo;
  logic [COUNT_WIDTH-1:0] walk_sh;
  logic [DATA_WIDTH-1:0]  pattern;

  assign hs        = m_valid & m_ready;
  assign last_beat = (sent_count == (num_q - COUNT_WIDTH'(1)));
  assign lfsr_step = (lfsr >> 1) ^ (lfsr[0] ? LFSR_POLY : 16'h0000);
  assign idx_lo    = DATA_WIDTH'(idx);
  assign walk_sh   = idx % COUNT_WIDTH'(DATA_WIDTH);
  assign busy      = (state == S_RUN);
  assign done      = (state == S_DONE);

  always_comb begin
    pattern = base_q;
    case (mode_q)
      2'd0:    pattern = base_q + idx_lo;
      2'd1:    pattern = base_q - idx_lo;
      2'd2:    pattern = base_q;
      default: pattern = DATA_WIDTH'(1) << walk_sh;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      lfsr       <= LFSR_INIT;
      m_valid    <= 1'b0;
      m_data     <= '0;
      idx        <= '0;
      sent_count <= '0;
      num_q      <= '0;
      mode_q     <= '0;
      base_q     <= '0;
      throttle_q <= '0;
    end else begin
      state      <= state_nxt;
      lfsr       <= lfsr_nxt;
      m_valid    <= valid_nxt;
      m_data     <= data_nxt;
      idx        <= idx_nxt;
      sent_count <= count_nxt;
      num_q      <= num_nxt;
      mode_q     <= mode_nxt;
      base_q     <= base_nxt;
      throttle_q <= throttle_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    lfsr_nxt     = lfsr;
    valid_nxt    = m_valid;
    data_nxt     = m_data;
    idx_nxt      = idx;
    count_nxt    = sent_count;
    num_nxt      = num_q;
    mode_nxt     = mode_q;
    base_nxt     = base_q;
    throttle_nxt = throttle_q;

    case (state)
      S_IDLE: begin
        if (start) begin
          num_nxt      = num_items;
          mode_nxt     = mode;
          base_nxt     = base;
          throttle_nxt = throttle;
          idx_nxt      = '0;
          count_nxt    = '0;
          state_nxt    = (num_items == '0) ? S_DONE : S_RUN;
        end
      end

      S_RUN: begin
        lfsr_nxt = lfsr_step;
        if (hs) count_nxt = sent_count + COUNT_WIDTH'(1);
        // A presented beat is never withdrawn; abort only takes effect at a handshake or while idle.
        if ((hs && (last_beat || abort)) || (abort && !m_valid)) begin
          valid_nxt = 1'b0;
          state_nxt = S_DONE;
        end else if ((!m_valid || hs) && (idx != num_q)) begin
          if (lfsr[3:0] < throttle_q) begin
            valid_nxt = 1'b0;
          end else begin
            valid_nxt = 1'b1;
            data_nxt  = pattern;
            idx_nxt   = idx + COUNT_WIDTH'(1);
          end
        end else if (hs) begin
          valid_nxt = 1'b0;
        end
      end

      S_DONE: state_nxt = S_IDLE;

      default: state_nxt = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_rv_stream_source.sv
`default_nettype none
// ============================================================================
// tb_rv_stream_source : directed self-checking bench for rv_stream_source
// Revision: 1.0
// ============================================================================
module tb_rv_stream_source;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] num_items = '0;
  logic [1:0]  mode = '0;
  logic [7:0]  base = '0;
  logic [3:0]  throttle = '0;
  logic        abort = 1'b0;
  logic        m_ready = 1'b1;
  logic        m_valid;
  logic [7:0]  m_data;
  logic        busy;
  logic        done;
  logic [15:0] sent_count;

  rv_stream_source #(
    .DATA_WIDTH (8),
    .COUNT_WIDTH(16),
    .LFSR_SEED  (16'hACE1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .num_items (num_items),
    .mode      (mode),
    .base      (base),
    .throttle  (throttle),
    .abort     (abort),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_ready   (m_ready),
    .busy      (busy),
    .done      (done),
    .sent_count(sent_count)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] got [0:31];
  int         got_n;
  int         done_cyc;
  int         stab_err;
  bit         timed_out;

  task automatic do_start(input logic [15:0] n, input logic [1:0] md,
                          input logic [7:0] b, input logic [3:0] th);
    @(negedge clk);
    num_items = n; mode = md; base = b; throttle = th; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Cycle 0 is the negedge right after the start edge; records accepted beats until done.
  task automatic collect(input int max_cyc, input logic [63:0] rdy_lo, input logic [63:0] abt);
    bit         pend;
    logic [7:0] pd;
    got_n = 0; done_cyc = -1; stab_err = 0; timed_out = 1'b1; pend = 1'b0; pd = '0;
    for (int c = 0; c < max_cyc; c++) begin
      m_ready = (c < 64) ? !rdy_lo[c] : 1'b1;
      abort   = (c < 64) ? abt[c] : 1'b0;
      #1;
      if (pend && (!m_valid || m_data !== pd)) stab_err++;
      if (done) begin
        done_cyc  = c;
        timed_out = 1'b0;
        break;
      end
      if (m_valid && m_ready) begin
        if (got_n < 32) got[got_n] = m_data;
        got_n++;
      end
      pend = m_valid && !m_ready;
      pd   = m_data;
      @(posedge clk);
      @(negedge clk);
    end
    m_ready = 1'b1;
    abort   = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", m_valid); end
    n_cmp++; if (m_data !== 8'h00) begin n_bad++; $display("FAIL reset_data got %h want 00", m_data); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
    n_cmp++; if (sent_count !== 16'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", sent_count); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    logic [7:0] exp [0:3];
    exp[0] = 8'hFE; exp[1] = 8'hFF; exp[2] = 8'h00; exp[3] = 8'h01;
    do_start(16'd4, 2'd0, 8'hFE, 4'd0);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy got %b want 1", busy); end
    n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL basic_first_valid got %b want 0", m_valid); end
    collect(40, 64'd0, 64'd0);
    n_cmp++; if (timed_out) begin n_bad++; $display("FAIL basic_timeout got timeout want done"); end
    n_cmp++; if (got_n !== 4) begin n_bad++; $display("FAIL basic_beats got %0d want 4", got_n); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (got[i] !== exp[i]) begin n_bad++; $display("FAIL basic_data[%0d] got %h want %h", i, got[i], exp[i]); end
    end
    n_cmp++; if (done_cyc !== 5) begin n_bad++; $display("FAIL basic_done_cycle got %0d want 5", done_cyc); end
    n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL basic_valid_at_done got %b want 0", m_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_at_done got %b want 0", busy); end
    n_cmp++; if (sent_count !== 16'd4) begin n_bad++; $display("FAIL basic_count got %0d want 4", sent_count); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL basic_done_width got %b want 0", done); end
    @(negedge clk);
    n_cmp++; if (sent_count !== 16'd4) begin n_bad++; $display("FAIL basic_count_hold got %0d want 4", sent_count); end
  endtask

  task automatic test_backpressure;
    logic [7:0] exp [0:3];
    exp[0] = 8'hFE; exp[1] = 8'hFF; exp[2] = 8'h00; exp[3] = 8'h01;
    do_start(16'd4, 2'd0, 8'hFE, 4'd0);
    collect(40, 64'b111_1100, 64'd0);
    n_cmp++; if (got_n !== 4) begin n_bad++; $display("FAIL bp_beats got %0d want 4", got_n); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (got[i] !== exp[i]) begin n_bad++; $display("FAIL bp_data[%0d] got %h want %h", i, got[i], exp[i]); end
    end
    n_cmp++; if (stab_err !== 0) begin n_bad++; $display("FAIL bp_stability got %0d want 0", stab_err); end
    n_cmp++; if (done_cyc !== 10) begin n_bad++; $display("FAIL bp_done_cycle got %0d want 10", done_cyc); end
    n_cmp++; if (sent_count !== 16'd4) begin n_bad++; $display("FAIL bp_count got %0d want 4", sent_count); end
    @(negedge clk);
  endtask

  task automatic test_walking;
    logic [7:0] exp [0:9];
    exp[0] = 8'h01; exp[1] = 8'h02; exp[2] = 8'h04; exp[3] = 8'h08; exp[4] = 8'h10;
    exp[5] = 8'h20; exp[6] = 8'h40; exp[7] = 8'h80; exp[8] = 8'h01; exp[9] = 8'h02;
    do_start(16'd10, 2'd3, 8'h00, 4'd0);
    collect(40, 64'd0, 64'd0);
    n_cmp++; if (got_n !== 10) begin n_bad++; $display("FAIL walk_beats got %0d want 10", got_n); end
    for (int i = 0; i < 10; i++) begin
      n_cmp++; if (got[i] !== exp[i]) begin n_bad++; $display("FAIL walk_data[%0d] got %h want %h", i, got[i], exp[i]); end
    end
    n_cmp++; if (done_cyc !== 11) begin n_bad++; $display("FAIL walk_done_cycle got %0d want 11", done_cyc); end
    @(negedge clk);
  endtask

  task automatic test_throttle;
    logic [7:0] e;
    do_start(16'd16, 2'd1, 8'h10, 4'd15);
    collect(4000, 64'd0, 64'd0);
    n_cmp++; if (timed_out) begin n_bad++; $display("FAIL thr_timeout got timeout want done"); end
    n_cmp++; if (got_n !== 16) begin n_bad++; $display("FAIL thr_beats got %0d want 16", got_n); end
    for (int i = 0; i < 16; i++) begin
      e = 8'h10 - 8'(i);
      n_cmp++; if (got[i] !== e) begin n_bad++; $display("FAIL thr_data[%0d] got %h want %h", i, got[i], e); end
    end
    n_cmp++; if (!(done_cyc > 17)) begin n_bad++; $display("FAIL thr_gaps got done at %0d want >17", done_cyc); end
    n_cmp++; if (sent_count !== 16'd16) begin n_bad++; $display("FAIL thr_count got %0d want 16", sent_count); end
    @(negedge clk);
  endtask

  task automatic test_abort;
    do_start(16'd4, 2'd2, 8'h5A, 4'd0);
    collect(40, 64'b1_1110, 64'b11_1100);
    n_cmp++; if (got_n !== 1) begin n_bad++; $display("FAIL abort_beats got %0d want 1", got_n); end
    n_cmp++; if (got[0] !== 8'h5A) begin n_bad++; $display("FAIL abort_data got %h want 5a", got[0]); end
    n_cmp++; if (stab_err !== 0) begin n_bad++; $display("FAIL abort_stability got %0d want 0", stab_err); end
    n_cmp++; if (done_cyc !== 6) begin n_bad++; $display("FAIL abort_done_cycle got %0d want 6", done_cyc); end
    n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL abort_valid got %b want 0", m_valid); end
    n_cmp++; if (sent_count !== 16'd1) begin n_bad++; $display("FAIL abort_count got %0d want 1", sent_count); end
    @(negedge clk);
  endtask

  task automatic test_zero;
    do_start(16'd0, 2'd0, 8'h33, 4'd0);
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL zero_done got %b want 1", done); end
    n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL zero_valid got %b want 0", m_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL zero_busy got %b want 0", busy); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0 || m_valid !== 1'b0) begin n_bad++; $display("FAIL zero_after got done=%b valid=%b want 0/0", done, m_valid); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] exp [0:2];
    exp[0] = 8'h20; exp[1] = 8'h21; exp[2] = 8'h22;
    do_start(16'd8, 2'd0, 8'h00, 4'd0);
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (m_valid !== 1'b1) begin n_bad++; $display("FAIL rmid_running got %b want 1", m_valid); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (m_valid !== 1'b0 || m_data !== 8'h00) begin n_bad++; $display("FAIL rmid_clear got valid=%b data=%h want 0/00", m_valid, m_data); end
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || sent_count !== 16'd0) begin n_bad++; $display("FAIL rmid_status got busy=%b done=%b cnt=%0d want 0/0/0", busy, done, sent_count); end
    @(negedge clk);
    rst_n = 1'b1;
    do_start(16'd3, 2'd0, 8'h20, 4'd0);
    collect(40, 64'd0, 64'd0);
    n_cmp++; if (got_n !== 3) begin n_bad++; $display("FAIL rmid_beats got %0d want 3", got_n); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (got[i] !== exp[i]) begin n_bad++; $display("FAIL rmid_data[%0d] got %h want %h", i, got[i], exp[i]); end
    end
    n_cmp++; if (done_cyc !== 4) begin n_bad++; $display("FAIL rmid_done_cycle got %0d want 4", done_cyc); end
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_backpressure;
    test_walking;
    test_throttle;
    test_abort;
    test_zero;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
